// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for the ID/EX register: ID-side inputs, hazard/flush controls, EX-side outputs.
// Perf counter signals appear only when ID_EX_PERF_CNT_EN is defined.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic              id_branch;
  logic              id_mem_read;
  logic              id_mem_to_reg;
  logic              id_mem_write;
  logic              id_alu_src;
  logic              id_reg_write;
  logic [1:0]        id_alu_op;
  logic              flush;
  logic              ex_stall;
  logic              id_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  logic              ex_branch;
  logic              ex_mem_read;
  logic              ex_mem_to_reg;
  logic              ex_mem_write;
  logic              ex_alu_src;
  logic              ex_reg_write;
  logic [1:0]        ex_alu_op;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       perf_bubble_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
           id_alu_src, id_reg_write, id_alu_op, flush, ex_stall,
    input  id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct3, ex_funct7, ex_branch, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op
`ifdef ID_EX_PERF_CNT_EN
    , input perf_bubble_cnt, perf_stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
           id_alu_src, id_reg_write, id_alu_op, flush, ex_stall,
    output id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct3, ex_funct7, ex_branch, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op
`ifdef ID_EX_PERF_CNT_EN
    , output perf_bubble_cnt, perf_stall_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle latency, load-use bubble insertion, hold on ex_stall, squash on flush.
// Optional ID_EX_PERF_CNT_EN adds saturating load-use-bubble and stall counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        alu_op;
  } ex_t;

  ex_t  ex_q, ex_d, id_pkt;
  logic load_use;

  // rs2 is compared even for I-type; a spurious one-cycle bubble is harmless.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & bus.id_valid
                  & ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
  assign bus.id_stall = load_use | bus.ex_stall;

  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = bus.id_valid;
    id_pkt.pc         = bus.id_pc;
    id_pkt.rs1_data   = bus.id_rs1_data;
    id_pkt.rs2_data   = bus.id_rs2_data;
    id_pkt.imm        = bus.id_imm;
    id_pkt.rs1        = bus.id_rs1;
    id_pkt.rs2        = bus.id_rs2;
    id_pkt.rd         = bus.id_rd;
    id_pkt.funct3     = bus.id_funct3;
    id_pkt.funct7     = bus.id_funct7;
    // Decoder asserts controls on unknown opcodes, so gate every control with id_valid.
    id_pkt.branch     = bus.id_branch     & bus.id_valid;
    id_pkt.mem_read   = bus.id_mem_read   & bus.id_valid;
    id_pkt.mem_to_reg = bus.id_mem_to_reg & bus.id_valid;
    id_pkt.mem_write  = bus.id_mem_write  & bus.id_valid;
    id_pkt.alu_src    = bus.id_alu_src    & bus.id_valid;
    id_pkt.reg_write  = bus.id_reg_write  & bus.id_valid & (bus.id_rd != '0);
    id_pkt.alu_op     = bus.id_alu_op     & {2{bus.id_valid}};

    ex_d = id_pkt;
    if (bus.flush)         ex_d = '0;
    else if (bus.ex_stall) ex_d = ex_q;
    else if (load_use)     ex_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1_data   = ex_q.rs1_data;
  assign bus.ex_rs2_data   = ex_q.rs2_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_funct7     = ex_q.funct7;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_alu_op     = ex_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, stall_cnt_q;
  logic        bubble_evt, stall_evt;

  // Flush outranks both events, so a flushed edge counts as neither.
  assign bubble_evt = ~bus.flush & ~bus.ex_stall & load_use;
  assign stall_evt  = ~bus.flush & bus.ex_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))   stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.perf_bubble_cnt = bubble_cnt_q;
  assign bus.perf_stall_cnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/stall/flush/reset scenarios plus random traffic against a reference model.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus();
  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc, rs1_data, rs2_data, imm;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]        alu_op;
  } view_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  view_t       m;
  view_t       saved;
  logic [31:0] m_bub, m_stl, stl_before;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic view_t dut_view();
    view_t v;
    v.valid = bus.ex_valid;       v.pc = bus.ex_pc;
    v.rs1_data = bus.ex_rs1_data; v.rs2_data = bus.ex_rs2_data; v.imm = bus.ex_imm;
    v.rs1 = bus.ex_rs1; v.rs2 = bus.ex_rs2; v.rd = bus.ex_rd;
    v.funct3 = bus.ex_funct3; v.funct7 = bus.ex_funct7;
    v.branch = bus.ex_branch; v.mem_read = bus.ex_mem_read; v.mem_to_reg = bus.ex_mem_to_reg;
    v.mem_write = bus.ex_mem_write; v.alu_src = bus.ex_alu_src; v.reg_write = bus.ex_reg_write;
    v.alu_op = bus.ex_alu_op;
    return v;
  endfunction

  // What EX should hold after loading the current decode slot.
  function automatic view_t id_view();
    view_t v;
    bit    ok;
    ok = bus.id_valid;
    v.valid = ok;                 v.pc = bus.id_pc;
    v.rs1_data = bus.id_rs1_data; v.rs2_data = bus.id_rs2_data; v.imm = bus.id_imm;
    v.rs1 = bus.id_rs1; v.rs2 = bus.id_rs2; v.rd = bus.id_rd;
    v.funct3 = bus.id_funct3; v.funct7 = bus.id_funct7;
    v.branch = ok && bus.id_branch;   v.mem_read = ok && bus.id_mem_read;
    v.mem_to_reg = ok && bus.id_mem_to_reg; v.mem_write = ok && bus.id_mem_write;
    v.alu_src = ok && bus.id_alu_src;
    v.reg_write = ok && bus.id_reg_write && (bus.id_rd != 0);
    v.alu_op = ok ? bus.id_alu_op : 2'b00;
    return v;
  endfunction

  function automatic bit m_hazard();
    return m.valid && m.mem_read && (m.rd != 0) && bus.id_valid &&
           ((m.rd == bus.id_rs1) || (m.rd == bus.id_rs2));
  endfunction

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_funct3 = 0; bus.id_funct7 = 0;
    bus.id_branch = 0; bus.id_mem_read = 0; bus.id_mem_to_reg = 0; bus.id_mem_write = 0;
    bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_alu_op = 0;
    bus.flush = 0; bus.ex_stall = 0;
  endtask

  task automatic rand_id();
    bus.id_valid = ($urandom_range(0, 3) != 0);
    bus.id_pc = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
    bus.id_imm = $urandom;
    bus.id_rs1 = 5'($urandom_range(0, 7)); bus.id_rs2 = 5'($urandom_range(0, 7));
    bus.id_rd = 5'($urandom_range(0, 7));
    bus.id_funct3 = 3'($urandom); bus.id_funct7 = 7'($urandom);
    bus.id_branch = 1'($urandom); bus.id_mem_read = 1'($urandom);
    bus.id_mem_to_reg = 1'($urandom); bus.id_mem_write = 1'($urandom);
    bus.id_alu_src = 1'($urandom); bus.id_reg_write = 1'($urandom);
    bus.id_alu_op = 2'($urandom);
  endtask

  // Check id_stall against current inputs, advance the model one edge, then check EX.
  task automatic step(input string tag);
    bit hz;
    #1;
    hz = m_hazard();
    chk({tag, ".id_stall"}, 256'(bus.id_stall), 256'(hz || bus.ex_stall));
    if (bus.flush) m = '0;
    else if (bus.ex_stall) begin
      if (m_stl != 32'hFFFF_FFFF) m_stl++;
    end else if (hz) begin
      m = '0;
      if (m_bub != 32'hFFFF_FFFF) m_bub++;
    end else m = id_view();
    @(posedge clk);
    #1;
    chk({tag, ".ex"}, 256'(dut_view()), 256'(m));
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".bub_cnt"}, 256'(bus.perf_bubble_cnt), 256'(m_bub));
    chk({tag, ".stl_cnt"}, 256'(bus.perf_stall_cnt), 256'(m_stl));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    m = '0; m_bub = 0; m_stl = 0;
    #12;
    chk("reset.ex", 256'(dut_view()), 256'(0));
    chk("reset.id_stall", 256'(bus.id_stall), 256'(0));
    #5 rst_n = 1;

    // R-type add
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_alu_op = 2'b10; bus.id_rd = 5;
    bus.id_rs1 = 1; bus.id_rs2 = 2; bus.id_rs1_data = 32'h11; bus.id_rs2_data = 32'h22;
    step("pass");
    chk("pass.valid", 256'(bus.ex_valid), 256'(1));
    chk("pass.reg_write", 256'(bus.ex_reg_write), 256'(1));
    chk("pass.alu_op", 256'(bus.ex_alu_op), 256'(2'b10));
    chk("pass.rs1_data", 256'(bus.ex_rs1_data), 256'(32'h11));
    chk("pass.rs2_data", 256'(bus.ex_rs2_data), 256'(32'h22));

    // lw x6 then add x8, x6, x7
    idle_inputs();
    bus.id_valid = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_reg_write = 1;
    bus.id_alu_src = 1; bus.id_rd = 6; bus.id_rs1 = 2; bus.id_imm = 4;
    step("lw");
    idle_inputs();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_alu_op = 2'b10;
    bus.id_rs1 = 6; bus.id_rs2 = 7; bus.id_rd = 8;
    #1 chk("lu.stall_hi", 256'(bus.id_stall), 256'(1));
    step("lu.bubble");
    chk("lu.bubble_valid", 256'(bus.ex_valid), 256'(0));
    chk("lu.bubble_mem_read", 256'(bus.ex_mem_read), 256'(0));
    chk("lu.bubble_reg_write", 256'(bus.ex_reg_write), 256'(0));
    chk("lu.stall_lo", 256'(bus.id_stall), 256'(0));
    step("lu.add");
    chk("lu.add_valid", 256'(bus.ex_valid), 256'(1));
    chk("lu.add_rs1", 256'(bus.ex_rs1), 256'(6));

    // x0 destination and invalid slot gating
    idle_inputs();
    bus.id_valid = 1; bus.id_rd = 0; bus.id_reg_write = 1;
    step("x0");
    chk("x0.reg_write", 256'(bus.ex_reg_write), 256'(0));
    chk("x0.valid", 256'(bus.ex_valid), 256'(1));
    bus.id_valid = 0; bus.id_rd = 3;
    step("inv");
    chk("inv.valid", 256'(bus.ex_valid), 256'(0));
    chk("inv.reg_write", 256'(bus.ex_reg_write), 256'(0));

    // three-cycle hold
    idle_inputs();
    rand_id(); bus.id_valid = 1; bus.id_mem_read = 0;
    step("hold.load");
    saved = dut_view();
    bus.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      #1 chk("hold.id_stall", 256'(bus.id_stall), 256'(1));
      step("hold");
      chk("hold.const", 256'(dut_view()), 256'(saved));
    end

    // flush beats ex_stall
    bus.flush = 1; bus.ex_stall = 1;
    stl_before = m_stl;
    step("flush");
    chk("flush.valid", 256'(bus.ex_valid), 256'(0));
`ifdef ID_EX_PERF_CNT_EN
    chk("flush.stl_cnt", 256'(bus.perf_stall_cnt), 256'(stl_before));
`endif
    bus.flush = 0; bus.ex_stall = 0;

    for (int i = 0; i < 2000; i++) begin
      rand_id();
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.ex_stall = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    // reset in the middle of a stall
    idle_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_reg_write = 1; bus.id_rd = 9;
    step("mrst.load");
    bus.ex_stall = 1;
    step("mrst.stall");
    #2 rst_n = 0;
    #1 chk("mrst.ex", 256'(dut_view()), 256'(0));
    bus.ex_stall = 0;
    #1 chk("mrst.id_stall", 256'(bus.id_stall), 256'(0));
`ifdef ID_EX_PERF_CNT_EN
    chk("mrst.stl_cnt", 256'(bus.perf_stall_cnt), 256'(0));
`endif
    m = '0; m_bub = 0; m_stl = 0;
    #3 rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      rand_id();
      bus.ex_stall = ($urandom_range(0, 3) == 0);
      step("post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined RV32IM core.
- Sits between the decode stage (register file read, immediate generation, main control decode) and the execute stage (ALU, ALU control, branch compare).
- Captures decoded control bits plus operands each cycle. Detects load-use hazards and inserts bubbles.
- Handles downstream-stall hold and branch-flush squash.

Parameters:
- XLEN, 32, datapath width for pc, operands and immediate
- REG_AW, 5, register-index width

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode slot holds a real instruction
- id_pc  input  XLEN  instruction PC
- id_rs1_data  input  XLEN  register file read port 1
- id_rs2_data  input  XLEN  register file read port 2
- id_imm  input  XLEN  sign-extended immediate
- id_rs1  input  REG_AW  source index 1
- id_rs2  input  REG_AW  source index 2
- id_rd  input  REG_AW  destination index
- id_funct3  input  3  instr[14:12]
- id_funct7  input  7  instr[31:25]
- id_branch  input  1  decoded branch control bit
- id_mem_read  input  1  decoded mem_read control bit
- id_mem_to_reg  input  1  decoded mem_to_reg control bit
- id_mem_write  input  1  decoded mem_write control bit
- id_alu_src  input  1  decoded alu_src control bit
- id_reg_write  input  1  decoded reg_write control bit
- id_alu_op  input  2  decoded ALU op class
- flush  input  1  branch taken in EX; squash ID/EX content
- ex_stall  input  1  EX cannot accept (e.g. multi-cycle M-op busy)
- id_stall  output  1  freeze PC and IF/ID this cycle
- ex_valid  output  1  EX slot valid
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  output  REG_AW  registered copies
- ex_funct3  output  3  registered copy
- ex_funct7  output  7  registered copy
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  output  1  registered controls
- ex_alu_op  output  2  registered control

Behaviour:
- Reset (async assert, sync release): every ex_* output is 0, including ex_valid and all controls.
- id_stall is combinational: load_use OR ex_stall.
- load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- rs2 is always compared; this is conservative for I-type instructions.
- Per-edge update priority, highest first:
  1. flush: load a bubble.
  2. ex_stall: hold all ex_* unchanged.
  3. load_use: load a bubble. The decode instruction stays in ID, because id_stall is high.
  4. Otherwise: load ID.
- Bubble: ex_valid=0, all control outputs=0, all data/index fields=0.
- Load ID:
  - ex_valid=id_valid.
  - Data/index fields copied.
  - Each control output = id_<ctrl> & id_valid. The decoder's default case asserts reg_write on unknown opcodes, so this gating is mandatory.
  - ex_reg_write additionally forced 0 when id_rd==0. Writes to x0 never leave this stage.
- Latency: one cycle from ID to EX outputs.
- A load-use bubble costs exactly one cycle. On the next edge ex_mem_read is 0, so load_use drops.
- Simultaneous flush+ex_stall: flush wins and the slot becomes a bubble. The flushing branch has completed EX.
- Simultaneous flush+load_use: bubble. id_stall is still asserted that cycle; the upstream flush overrides it in IF/ID.
- Reset mid-stall: outputs clear immediately. Pipeline restarts empty.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Extra outputs perf_bubble_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_bubble_cnt increments on each edge where a load_use bubble is loaded. Flush bubbles are not counted.
  - perf_stall_cnt increments on each edge where ex_stall holds the register.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: ports and logic are absent, and the module is otherwise identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ex_valid=1 -> all ex_* go to 0 asynchronously; id_stall=0.
- Pass-through:
  - Stimulus: id_valid=1, R-type add (reg_write=1, alu_op=2'b10), rd=5, rs1_data=0x11, rs2_data=0x22.
  - Response: next cycle ex_valid=1, ex_reg_write=1, ex_alu_op=2'b10, ex_rs1_data=0x11, ex_rs2_data=0x22.
- Load-use:
  - Stimulus: lw x6 in EX, then add with rs1=6 in ID.
  - Response: id_stall=1 for one cycle; next edge loads a bubble (ex_valid=0, controls 0); following edge loads the add; id_stall=0.
- x0 and invalid gating:
  - Stimulus: id_valid=1, rd=0, reg_write=1 -> ex_reg_write=0.
  - Stimulus: id_valid=0, reg_write=1 -> ex_valid=0, ex_reg_write=0.
- ex_stall hold: hold ex_stall=1 for 3 cycles while ID inputs change -> ex_* constant; id_stall=1 throughout.
- Flush priority: flush=1 and ex_stall=1 together -> bubble; with ID_EX_PERF_CNT_EN, perf_stall_cnt unchanged.
